pcm_stream_feeder: RTL and testbench

Upstream stage of audio_stereo_out, in the clk_pcm domain. Paces stereo PCM playback at a fixed sample rate, fetches each {left,right} sample from a sample memory over a req/ack read port, and pushes it into the audio_stereo_out FIFO via stereo_pcm/stereo_pcm_rdy, honouring fifo_full. Supports one-shot and looped playback of an address range and counts missed sample periods (underruns).

---
 rtl/audio_pkg.sv | 25 ++
 rtl/pcm_stream_feeder_if.sv | 30 +++
 rtl/pcm_rate_tick.sv | 32 +++
 rtl/pcm_stream_feeder.sv | 181 ++++++++++++++++++
 tb/tb_pcm_stream_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio playback stages.
//
// Contents:
//   DEF_SAMPLE_DIV, DEF_ADDR_W, DEF_SAMPLE_W : default build constants
//   feeder_state_t                           : pcm_stream_feeder state encoding
//   sat_inc16()                              : saturating 16-bit increment
package audio_pkg;

    localparam int unsigned DEF_SAMPLE_DIV = 2500; // 50 MHz / 2500 = 20 kHz
    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_SAMPLE_W   = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StFetch,
        StPush,
        StDone
    } feeder_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcm_stream_feeder_if.sv
// Sample-memory read port plus FIFO write port of pcm_stream_feeder.
//
// Signals:
//   mem_rd, mem_addr          : read request / address (feeder -> memory)
//   mem_ack, mem_data         : one-cycle ack with {left,right} data (memory -> feeder)
//   fifo_full                 : back-pressure from audio_stereo_out
//   stereo_pcm, stereo_pcm_rdy: sample word and one-cycle write strobe (feeder -> FIFO)
// Modports: master = feeder side, slave = memory/FIFO side.
interface pcm_stream_feeder_if #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned SAMPLE_W = 8
);
    logic                  mem_rd;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [2*SAMPLE_W-1:0] mem_data;
    logic                  fifo_full;
    logic [2*SAMPLE_W-1:0] stereo_pcm;
    logic                  stereo_pcm_rdy;

    modport master (
        output mem_rd, mem_addr, stereo_pcm, stereo_pcm_rdy,
        input  mem_ack, mem_data, fifo_full
    );

    modport slave (
        input  mem_rd, mem_addr, stereo_pcm, stereo_pcm_rdy,
        output mem_ack, mem_data, fifo_full
    );
endinterface

// File: rtl/pcm_rate_tick.sv
// Sample-rate pacing counter: counts 0..DIV-1 while en is high and wraps.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear to 0 (dominates en)
//   en       : count enable
//   tick     : high while enabled and count == DIV-1
module pcm_rate_tick #(
    parameter int unsigned DIV = 2500
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] count;

    assign tick = en && (count == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/pcm_stream_feeder.sv
// Paces stereo PCM playback: at every sample tick fetches one {left,right} word from sample
// memory and writes it into the audio_stereo_out FIFO. One-shot or looped address range,
// saturating count of missed sample periods.
//
// Ports:
//   clk_pcm, aclr          : clock, asynchronous active-high reset
//   enable, loop           : playback run level, loop-at-end select
//   start_addr, end_addr   : address range, latched when playback starts
//   vol_left, vol_right    : per-channel right-shift attenuation (PCM_VOLUME_EN only)
//   bus                    : memory read port and FIFO write port (master modport)
//   busy, done             : status
//   underrun_count         : saturating missed-period count
// Optional build macro: PCM_VOLUME_EN adds the vol_* ports.
module pcm_stream_feeder
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W
) (
    input  logic                clk_pcm,
    input  logic                aclr,
    input  logic                enable,
    input  logic                loop,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
`ifdef PCM_VOLUME_EN
    input  logic [2:0]          vol_left,
    input  logic [2:0]          vol_right,
`endif
    pcm_stream_feeder_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [15:0]         underrun_count
);
    localparam int unsigned W = 2 * SAMPLE_W;

    feeder_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] start_r;
    logic [ADDR_W-1:0] end_r;
    logic [W-1:0]      word_r;
    logic [W-1:0]      mem_word;
    logic [W-1:0]      push_word;
    logic [W-1:0]      stereo_pcm;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              stereo_pcm_rdy;
    logic              tick;
    logic              count_clear;
    logic              push_now;
    logic              at_end;

    assign bus.mem_rd         = mem_rd;
    assign bus.mem_addr       = mem_addr;
    assign bus.stereo_pcm     = stereo_pcm;
    assign bus.stereo_pcm_rdy = stereo_pcm_rdy;

    // Counter only runs in the busy states so each playback starts a full period from zero.
    assign count_clear = ~busy;

    pcm_rate_tick #(
        .DIV (SAMPLE_DIV)
    ) u_rate_tick (
        .clk   (clk_pcm),
        .rst   (aclr),
        .clear (count_clear),
        .en    (busy),
        .tick  (tick)
    );

`ifdef PCM_VOLUME_EN
    assign mem_word = {bus.mem_data[W-1:SAMPLE_W] >> vol_left,
                       bus.mem_data[SAMPLE_W-1:0] >> vol_right};
`else
    assign mem_word = bus.mem_data;
`endif

    // A word is written straight from the ack cycle when the FIFO has room; PUSH only holds a
    // word that met a full FIFO. This keeps ack -> strobe at one cycle.
    always_comb begin
        push_word = word_r;
        if (state == StFetch) begin
            push_word = mem_word;
        end
        push_now = enable && !bus.fifo_full &&
                   ((state == StFetch && bus.mem_ack) || state == StPush);
        at_end   = (addr == end_r);
    end

    always_ff @(posedge clk_pcm or posedge aclr) begin
        if (aclr) begin
            state          <= StIdle;
            addr           <= '0;
            start_r        <= '0;
            end_r          <= '0;
            word_r         <= '0;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
            stereo_pcm     <= '0;
            stereo_pcm_rdy <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            underrun_count <= '0;
        end else begin
            stereo_pcm_rdy <= 1'b0;

            // A tick while still fetching or stalled drops that period; no catch-up.
            if (tick && (state == StFetch || state == StPush)) begin
                underrun_count <= sat_inc16(underrun_count);
            end

            if (push_now) begin
                mem_rd         <= 1'b0;
                stereo_pcm     <= push_word;
                stereo_pcm_rdy <= 1'b1;
                if (at_end && !loop) begin
                    state <= StDone;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= StWaitTick;
                    addr  <= at_end ? start_r : addr + 1'b1;
                end
            end else begin
                case (state)
                    StIdle: begin
                        if (enable) begin
                            start_r        <= start_addr;
                            end_r          <= end_addr;
                            addr           <= start_addr;
                            underrun_count <= '0;
                            busy           <= 1'b1;
                            state          <= StWaitTick;
                        end
                    end
                    StWaitTick: begin
                        if (!enable) begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end else if (tick) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= addr;
                            state    <= StFetch;
                        end
                    end
                    StFetch: begin
                        // The read always completes; a disabled feeder discards the word.
                        if (bus.mem_ack) begin
                            mem_rd <= 1'b0;
                            if (!enable) begin
                                busy  <= 1'b0;
                                state <= StIdle;
                            end else begin
                                word_r <= mem_word;
                                state  <= StPush;
                            end
                        end
                    end
                    StPush: begin
                        if (!enable) begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end
                    end
                    StDone: begin
                        if (!enable) begin
                            done  <= 1'b0;
                            state <= StIdle;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        state <= StIdle;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pcm_stream_feeder.sv
// Self-checking bench for pcm_stream_feeder with SAMPLE_DIV = 8. A memory model answers
// reads and pushes the expected FIFO word into a scoreboard queue; a monitor pops and compares
// on every stereo_pcm_rdy strobe.
module tb_pcm_stream_feeder;
    import audio_pkg::*;

    localparam int unsigned DIV = 8;
    localparam int unsigned AW  = 16;
    localparam int unsigned SW  = 8;

    logic        clk_pcm = 1'b0;
    logic        aclr;
    logic        enable;
    logic        loop;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic        busy;
    logic        done;
    logic [15:0] underrun_count;
`ifdef PCM_VOLUME_EN
    logic [2:0]  vol_left;
    logic [2:0]  vol_right;
`endif

    pcm_stream_feeder_if #(.ADDR_W(AW), .SAMPLE_W(SW)) bus ();

    pcm_stream_feeder #(
        .SAMPLE_DIV (DIV),
        .ADDR_W     (AW),
        .SAMPLE_W   (SW)
    ) dut (
        .clk_pcm        (clk_pcm),
        .aclr           (aclr),
        .enable         (enable),
        .loop           (loop),
        .start_addr     (start_addr),
        .end_addr       (end_addr),
`ifdef PCM_VOLUME_EN
        .vol_left       (vol_left),
        .vol_right      (vol_right),
`endif
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .underrun_count (underrun_count)
    );

    always #5 clk_pcm = ~clk_pcm;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk_pcm) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] mem [0:255];
    logic [15:0] exp_addr_q [$];
    logic [15:0] exp_word_q [$];
    int          ack_delay = 0;
    bit          mem_auto = 1'b1;
    int          wait_cnt = 0;
    logic [15:0] req_addr;
    bit          addr_stable;
    int          strobes = 0;
    int          last_strobe = 0;
    bit          check_spacing = 1'b0;
    bit          done_seen = 1'b0;

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef PCM_VOLUME_EN
        return {w[15:8] >> vol_left, w[7:0] >> vol_right};
`else
        return w;
`endif
    endfunction

    // Memory model: acks ack_delay+1 cycles after mem_rd rises, one-cycle ack.
    initial begin
        logic [15:0] a;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk_pcm);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (mem_auto && bus.mem_rd) begin
                if (wait_cnt == 0) begin
                    req_addr    = bus.mem_addr;
                    addr_stable = 1'b1;
                end else if (bus.mem_addr !== req_addr) begin
                    addr_stable = 1'b0;
                end
                wait_cnt++;
                if (wait_cnt > ack_delay) begin
                    check("addr_stable", 32'(addr_stable), 32'd1);
                    if (exp_addr_q.size() == 0) begin
                        check("addr_expected", 32'(exp_addr_q.size()), 32'd1);
                    end else begin
                        a = exp_addr_q.pop_front();
                        check("mem_addr", 32'(bus.mem_addr), 32'(a));
                        exp_word_q.push_back(exp_word(mem[a[7:0]]));
                    end
                    bus.mem_data = mem[bus.mem_addr[7:0]];
                    bus.mem_ack  = 1'b1;
                    wait_cnt     = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Output monitor / scoreboard pop.
    initial begin
        forever begin
            @(negedge clk_pcm);
            if (done) done_seen = 1'b1;
            if (bus.stereo_pcm_rdy) begin
                strobes++;
                if (exp_word_q.size() == 0) begin
                    check("strobe_expected", 32'(exp_word_q.size()), 32'd1);
                end else begin
                    check("stereo_pcm", 32'(bus.stereo_pcm), 32'(exp_word_q.pop_front()));
                end
                if (check_spacing && strobes > 1) begin
                    check("strobe_spacing", 32'(cyc - last_strobe), 32'(DIV));
                end
                last_strobe = cyc;
            end
        end
    end

    task automatic tick_wait(input int n);
        repeat (n) @(negedge clk_pcm);
        #1;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int i = 0;
        while (strobes < n && i < budget) begin
            @(negedge clk_pcm);
            #1;
            i++;
        end
        check("strobe_count", 32'(strobes), 32'(n));
    endtask

    task automatic wait_rd(input int budget);
        int i = 0;
        while (!bus.mem_rd && i < budget) begin
            @(negedge clk_pcm);
            #1;
            i++;
        end
        check("mem_rd_seen", 32'(bus.mem_rd), 32'd1);
    endtask

    task automatic stop_play();
        enable = 1'b0;
        tick_wait(2);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101 + 16'h0011);
        mem[0]   = 16'h7F00;
        mem[1]   = 16'h007F;
        mem[2]   = 16'h7F7F;
        mem[3]   = 16'h0000;
        mem[5]   = 16'hA55A;
        mem[6]   = 16'h7F7F;
        mem[9]   = 16'h1234;
        mem[254] = 16'hC0DE;
        mem[255] = 16'hFACE;
        aclr          = 1'b1;
        enable        = 1'b0;
        loop          = 1'b0;
        start_addr    = '0;
        end_addr      = '0;
        bus.fifo_full = 1'b0;
`ifdef PCM_VOLUME_EN
        vol_left  = 3'd0;
        vol_right = 3'd0;
`endif
        tick_wait(3);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_pcm", 32'(bus.stereo_pcm), 32'd0);
        check("rst_rdy", 32'(bus.stereo_pcm_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underrun", 32'(underrun_count), 32'd0);
        aclr = 1'b0;
        tick_wait(2);

        // One-shot 0..3.
        for (int a = 0; a < 4; a++) exp_addr_q.push_back(16'(a));
        start_addr    = 16'd0;
        end_addr      = 16'd3;
        strobes       = 0;
        check_spacing = 1'b1;
        enable        = 1'b1;
        tick_wait(1);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_strobes(4, 200);
        check("oneshot_done", 32'(done), 32'd1);
        check("oneshot_busy", 32'(busy), 32'd0);
        check("oneshot_underrun", 32'(underrun_count), 32'd0);
        tick_wait(DIV * 2);
        check("oneshot_no_more", 32'(strobes), 32'd4);
        stop_play();

        // Looped 0..3, ten samples, then disable from WAIT_TICK.
        for (int k = 0; k < 10; k++) exp_addr_q.push_back(16'(k % 4));
        loop      = 1'b1;
        strobes   = 0;
        done_seen = 1'b0;
        enable    = 1'b1;
        wait_strobes(10, 300);
        enable = 1'b0;
        tick_wait(1);
        check("loop_stop_busy", 32'(busy), 32'd0);
        check("loop_done_seen", 32'(done_seen), 32'd0);
        check("loop_underrun", 32'(underrun_count), 32'd0);
        check("loop_sb_empty", 32'(exp_word_q.size() + exp_addr_q.size()), 32'd0);
        check_spacing = 1'b0;
        loop          = 1'b0;
        tick_wait(2);

        // Wrapping range FFFE..0001.
        exp_addr_q.push_back(16'hFFFE);
        exp_addr_q.push_back(16'hFFFF);
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h0001);
        start_addr = 16'hFFFE;
        end_addr   = 16'h0001;
        strobes    = 0;
        enable     = 1'b1;
        wait_strobes(4, 200);
        check("wrap_done", 32'(done), 32'd1);
        stop_play();

        // FIFO full for 20 cycles while the word sits in PUSH.
        exp_addr_q.push_back(16'd5);
        start_addr = 16'd5;
        end_addr   = 16'd5;
        strobes    = 0;
        enable     = 1'b1;
        wait_rd(50);
        bus.fifo_full = 1'b1;
        tick_wait(20);
        check("full_no_strobe", 32'(strobes), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        bus.fifo_full = 1'b0;
        wait_strobes(1, 20);
        check("full_underrun", 32'(underrun_count), 32'd2);
        check("full_done", 32'(done), 32'd1);
        stop_play();

        // Slow memory: ack 10 cycles late.
        exp_addr_q.push_back(16'd9);
        start_addr = 16'd9;
        end_addr   = 16'd9;
        ack_delay  = 10;
        strobes    = 0;
        enable     = 1'b1;
        wait_strobes(1, 100);
        check("slow_underrun", 32'(underrun_count), 32'd1);
        check("slow_done", 32'(done), 32'd1);
        ack_delay = 0;
        stop_play();

`ifdef PCM_VOLUME_EN
        exp_addr_q.push_back(16'd6);
        vol_left   = 3'd1;
        vol_right  = 3'd7;
        start_addr = 16'd6;
        end_addr   = 16'd6;
        strobes    = 0;
        enable     = 1'b1;
        wait_strobes(1, 100);
        check("vol_pcm", 32'(bus.stereo_pcm), 32'h3F00);
        vol_left  = 3'd0;
        vol_right = 3'd0;
        stop_play();
`endif

        // Reset in the middle of a fetch, then a stray ack.
        mem_auto   = 1'b0;
        start_addr = 16'd2;
        end_addr   = 16'd2;
        strobes    = 0;
        enable     = 1'b1;
        wait_rd(50);
        tick_wait(2);
        check("fetch_hold_rd", 32'(bus.mem_rd), 32'd1);
        aclr = 1'b1;
        #1;
        check("aclr_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("aclr_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("aclr_pcm", 32'(bus.stereo_pcm), 32'd0);
        check("aclr_busy", 32'(busy), 32'd0);
        check("aclr_underrun", 32'(underrun_count), 32'd0);
        enable = 1'b0;
        tick_wait(1);
        aclr = 1'b0;
        tick_wait(1);
        bus.mem_data = 16'hBEEF;
        bus.mem_ack  = 1'b1;
        tick_wait(6);
        check("stray_ack_strobes", 32'(strobes), 32'd0);
        check("stray_ack_busy", 32'(busy), 32'd0);
        check("stray_ack_pcm", 32'(bus.stereo_pcm), 32'd0);
        mem_auto = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
